// File: rtl/base_pkg.sv
// Shared state encoding for the base_* beat handling blocks.
package base_pkg;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

endpackage

// File: rtl/base_arepeat_ctr.sv
// Copy counter for base_arepeat: rem counts down the copies still to emit,
// idx counts up, first/last are registered decodes of the current copy.
module base_arepeat_ctr #(
    parameter int cwidth = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              dec,
    input  logic [cwidth-1:0] cnt,
    output logic [cwidth-1:0] rem,
    output logic [cwidth-1:0] idx,
    output logic              first,
    output logic              last
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem   <= '0;
            idx   <= '0;
            first <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            // A zero count loads an empty counter, which leaves the block idle.
            rem   <= cnt;
            idx   <= '0;
            first <= (cnt != '0);
            last  <= (cnt == cwidth'(1));
        end else if (dec) begin
            rem   <= rem - cwidth'(1);
            idx   <= (rem == cwidth'(1)) ? '0 : idx + cwidth'(1);
            first <= 1'b0;
            last  <= (rem == cwidth'(2));
        end
    end

endmodule

// File: rtl/base_arepeat.sv
// Valid/ready beat expander: each accepted beat is emitted i_cnt times with
// first/last/index tags. Define BASE_AREPEAT_INC_EN to step o_d by one per copy.
module base_arepeat
    import base_pkg::*;
#(
    parameter int width  = 1,
    parameter int cwidth = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_v,
    output logic              i_r,
    input  logic [width-1:0]  i_d,
    input  logic [cwidth-1:0] i_cnt,
    output logic              o_v,
    input  logic              o_r,
    output logic [width-1:0]  o_d,
    output logic              o_first,
    output logic              o_last,
    output logic [cwidth-1:0] o_idx
);

    // Handshake: a beat moves on a port when valid and ready are both high in
    // the same cycle; valid never waits for ready, and o_v has no path from i_v.
    logic              state;
    logic [cwidth-1:0] rem;
    logic              take;
    logic              last_take;
    logic              accept;
    logic              cnt_nz;

    assign o_v       = (state == STATE_BUSY);
    assign take      = o_v & o_r;
    assign last_take = take & (rem == cwidth'(1));
    assign i_r       = (state == STATE_IDLE) | last_take;
    assign accept    = i_v & i_r;
    assign cnt_nz    = (i_cnt != '0);

    base_arepeat_ctr #(
        .cwidth (cwidth)
    ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .dec   (take & ~accept),
        .cnt   (i_cnt),
        .rem   (rem),
        .idx   (o_idx),
        .first (o_first),
        .last  (o_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STATE_IDLE;
        end else if (accept) begin
            state <= cnt_nz ? STATE_BUSY : STATE_IDLE;
        end else if (last_take) begin
            state <= STATE_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_d <= '0;
        end else if (accept & cnt_nz) begin
            o_d <= i_d;
`ifdef BASE_AREPEAT_INC_EN
        end else if (take & ~last_take) begin
            o_d <= o_d + width'(1);
`endif
        end
    end

endmodule

// File: tb/tb_base_arepeat.sv
// Directed bench for base_arepeat: expected copies are queued when a beat is
// issued and a negedge monitor pops and compares them on every output take.
module tb_base_arepeat;

    localparam int WIDTH  = 8;
    localparam int CWIDTH = 4;
    localparam int W      = WIDTH + CWIDTH + 2;

    logic              clk;
    logic              reset;
    logic              i_v;
    logic              i_r;
    logic [WIDTH-1:0]  i_d;
    logic [CWIDTH-1:0] i_cnt;
    logic              o_v;
    logic              o_r;
    logic [WIDTH-1:0]  o_d;
    logic              o_first;
    logic              o_last;
    logic [CWIDTH-1:0] o_idx;

    base_arepeat #(
        .width  (WIDTH),
        .cwidth (CWIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_v     (i_v),
        .i_r     (i_r),
        .i_d     (i_d),
        .i_cnt   (i_cnt),
        .o_v     (o_v),
        .o_r     (o_r),
        .o_d     (o_d),
        .o_first (o_first),
        .o_last  (o_last),
        .o_idx   (o_idx)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           take_cyc[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_takes  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_beat(input logic [7:0] d, input int cnt, input int nexp);
        logic [7:0] dd;
        for (int k = 0; k < nexp; k++) begin
            dd = d;
`ifdef BASE_AREPEAT_INC_EN
            dd = d + 8'(k);
`endif
            exp_q.push_back({dd, 4'(k), k == 0, k == cnt - 1});
        end
    endtask

    // monitor
    logic         hold_prev = 1'b0;
    logic [W-1:0] snap;
    logic [W-1:0] got;

    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            got = {o_d, o_idx, o_first, o_last};
            check("i_r", i_r, !o_v | (o_r & o_last));
            if (hold_prev) begin
                check("hold_v", o_v, 1);
                check("hold_out", got, snap);
            end
            if (o_v && o_r) begin
                n_takes++;
                take_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("unexpected_take", got, 0);
                else check("beat", got, exp_q.pop_front());
            end
            hold_prev = o_v & !o_r;
            snap      = got;
        end
    end

    // driver tasks
    task automatic send(input logic [7:0] d, input int c, output int acc_cyc);
        i_v     = 1'b1;
        i_d     = d;
        i_cnt   = 4'(c);
        acc_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (i_r) begin
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 1, 0);
    endtask

    task automatic idle();
        i_v   = 1'b0;
        i_cnt = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    int a;
    int a2;
    int t0;
    int start;
    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        reset = 1'b1;
        i_v   = 1'b0;
        i_d   = '0;
        i_cnt = '0;
        o_r   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_v", o_v, 0);
        check("rst_o_d", o_d, 0);
        check("rst_o_idx", o_idx, 0);
        check("rst_o_first", o_first, 0);
        check("rst_o_last", o_last, 0);
        check("rst_i_r", i_r, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: cnt=3, three consecutive copies, accept-to-valid latency of one cycle
        o_r = 1'b1;
        t0  = take_cyc.size();
        push_beat(8'hA5, 3, 3);
        send(8'hA5, 3, a);
        idle();
        drain();
        check("t1_takes", take_cyc.size() - t0, 3);
        if (take_cyc.size() - t0 == 3) begin
            check("t1_latency", take_cyc[t0], a + 1);
            check("t1_span", take_cyc[t0+2] - take_cyc[t0], 2);
        end

        // 2: zero-count beats are swallowed the cycle they are presented
        t0 = take_cyc.size();
        for (int k = 0; k < 4; k++) begin
            start = cyc;
            send(8'(8'h10 + k), 0, a);
            check("t2_same_cycle", a, start);
            check("t2_o_v", o_v, 0);
        end
        idle();
        repeat (3) begin
            @(negedge clk);
            check("t2_o_v_quiet", o_v, 0);
        end
        check("t2_takes", take_cyc.size() - t0, 0);
        @(posedge clk);
        #1;

        // 3: cnt=2 then cnt=1 back to back, no bubble between beats
        t0 = take_cyc.size();
        push_beat(8'h11, 2, 2);
        push_beat(8'h22, 1, 1);
        send(8'h11, 2, a);
        send(8'h22, 1, a2);
        idle();
        drain();
        check("t3_takes", take_cyc.size() - t0, 3);
        if (take_cyc.size() - t0 == 3) begin
            check("t3_span", take_cyc[t0+2] - take_cyc[t0], 2);
            check("t3_overlap", a2, take_cyc[t0+1]);
        end

        // 4: cnt=4 under downstream backpressure
        t0 = take_cyc.size();
        push_beat(8'h5A, 4, 4);
        send(8'h5A, 4, a);
        idle();
        for (int k = 0; k < 7; k++) begin
            o_r = pat[k];
            @(posedge clk);
            #1;
        end
        o_r = 1'b1;
        check("t4_takes", take_cyc.size() - t0, 4);
        check("t4_o_v_done", o_v, 0);
        drain();

        // 5: async reset during copy index 2 of a cnt=5 beat
        push_beat(8'h77, 5, 2);
        send(8'h77, 5, a);
        idle();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_o_v", o_v, 0);
        check("t5_async_idx", o_idx, 0);
        check("t5_async_i_r", i_r, 1);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t5_queue_clear", exp_q.size(), 0);
        exp_q.delete();
        push_beat(8'h3C, 2, 2);
        send(8'h3C, 2, a);
        idle();
        check("t5_restart_idx", o_idx, 0);
        check("t5_restart_first", o_first, 1);
        drain();

        // 6: data stepping across copies (constant without the increment option)
        push_beat(8'hFE, 3, 3);
        send(8'hFE, 3, a);
        idle();
        drain();

        check("end_queue", exp_q.size(), 0);
        check("end_takes", n_takes, 17);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
